act_layer_sequencer: RTL
========================

Name: act_layer_sequencer

Overview:
- Controller that sequences one activation job through the activation unit. A job is one systolic-array result matrix, delivered as NUM_DIAGS diagonal wavefront vectors.
- Accepts wavefront vectors from the array drain over a valid/ready handshake and latches the job's activation type.
- Issues one start pulse per wavefront to the activation unit, flags the last wavefront with input_done, and waits for output_complete before reporting job_done.
- Sits between the systolic array output stage and activation_layer; the top-level controller owns job_start and job_done.

Parameters:
- DATA_WIDTH, 32, width of one accumulator value.
- MAT_ROWS, 3, result matrix rows.
- MAT_COLS, 3, result matrix columns.
- NUM_VALUES, MAT_ROWS+MAT_COLS-1, values per wavefront vector.
- NUM_DIAGS, (MAT_ROWS>=MAT_COLS?MAT_ROWS:MAT_COLS), wavefronts per job (must be >=1).
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- job_start  in  1  single-cycle job request; honoured only in IDLE.
- job_act_type  in  2  activation select (00 ReLU, 01 Sigmoid, 10 Tanh, 11 Identity); sampled with job_start.
- job_busy  out  1  high whenever state != IDLE.
- job_done  out  1  one-cycle pulse at job completion.
- vec_valid  in  1  wavefront vector valid.
- vec_data  in  DATA_WIDTH*NUM_VALUES  wavefront vector.
- vec_ready  out  1  sequencer can accept a vector.
- act_start  out  1  one-cycle start pulse to the activation unit.
- act_input_done  out  1  one-cycle pulse marking the last wavefront.
- act_type  out  2  latched activation type.
- act_in_value  out  DATA_WIDTH*NUM_VALUES  registered vector to the activation unit.
- act_ready  in  1  activation unit idle.
- act_output_done  in  1  activation unit finished the current wavefront (pulse).
- act_output_complete  in  1  activation unit has flattened the full matrix (level).
- diag_cnt  out  8  wavefronts completed in the current job.
- err  out  1  watchdog error flag (optional feature only; otherwise tied 0).

Behaviour:
- Reset values: all outputs 0, state IDLE, act_in_value 0, act_type 00. Reset mid-job aborts immediately; no job_done is produced.
- States: IDLE, WAIT_VEC, WAIT_ACK, WAIT_CPL, FINISH (plus ERR with the optional feature).
- IDLE: on job_start, latch job_act_type into act_type, clear diag_cnt, go to WAIT_VEC next cycle. job_start in any other state is ignored.
- WAIT_VEC: vec_ready = act_ready (combinational, this state only). On a handshake (vec_valid & vec_ready) at edge N:
  - act_in_value <= vec_data.
  - act_start = 1 during cycle N+1 only.
  - act_input_done = 1 in the same cycle iff diag_cnt == NUM_DIAGS-1.
  - Go to WAIT_ACK.
- WAIT_ACK: vec_ready = 0. On act_output_done:
  - diag_cnt <= diag_cnt+1.
  - If the new count == NUM_DIAGS, go to WAIT_CPL; else go to WAIT_VEC.
- WAIT_CPL: when act_output_complete = 1, go to FINISH. If it is already high on entry, transition on the next edge.
- FINISH: job_done = 1 for one cycle, then IDLE. diag_cnt holds its final value until the next job_start.
- act_output_done arriving outside WAIT_ACK is ignored.
- act_in_value and act_type are stable from act_start until the next handshake.
- Minimum per-wavefront cost: 1 cycle handshake + activation unit latency + 1 cycle. No overlap between wavefronts.
- NUM_DIAGS = 1: the first and only act_start carries act_input_done.

Optional Feature:
- Macro: ACT_SEQ_TIMEOUT_EN.
- Defined: a 16-bit watchdog counts cycles spent in WAIT_ACK or WAIT_CPL and clears on every state change.
  - When the count reaches TIMEOUT_CYCLES: enter ERR, err <= 1, job_busy stays 1.
  - ERR exits to IDLE only on job_start, which also clears err and starts the new job normally.
- Not defined: no counter and no ERR state; err is tied 0; WAIT_ACK/WAIT_CPL wait indefinitely.

Test Plan:
- Nominal job (3x3, NUM_DIAGS = 3): job_start with type 00, then vectors 0x...01, 0x...02, 0x...03, each followed by an act_output_done, act_output_complete high after the third.
  -> Exactly 3 act_start pulses; act_input_done only with the third; diag_cnt steps 1,2,3; one job_done pulse; act_type = 00 throughout.
- Backpressure: hold act_ready = 0 for 5 cycles in WAIT_VEC with vec_valid = 1.
  -> vec_ready = 0 for all 5 cycles; vec_data is accepted on the first cycle act_ready = 1; act_start follows one cycle later.
- Busy rejection: job_start with type 10 pulsed while in WAIT_ACK.
  -> act_type stays at the original value; diag_cnt and the FSM are unaffected.
- Reset mid-job: assert rst after the second act_start.
  -> All outputs 0 immediately; state IDLE; no job_done; a new job then completes normally.
- Late completion: act_output_complete rises 10 cycles after the third act_output_done.
  -> job_busy = 1 throughout the wait; job_done pulses exactly 1 cycle after the rise.
- With ACT_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 16: withhold act_output_done.
  -> err = 1 after 16 cycles in WAIT_ACK; a subsequent job_start clears err and the job runs to job_done.

Source files
------------

// File: rtl/act_layer_sequencer.sv
// ---------------------------------------------------------------------------
// act_layer_sequencer
//
// Walks one activation job through the activation unit. A job is one
// systolic-array result matrix that arrives as NUM_DIAGS diagonal wavefront
// vectors. Each accepted vector is registered and handed to the activation
// unit with a one-cycle start pulse. The last wavefront is tagged with
// act_input_done. After every wavefront has been acknowledged, the sequencer
// waits for the unit to report the flattened matrix. It then pulses job_done.
//
// Optional feature: define ACT_SEQ_TIMEOUT_EN to add a 16-bit watchdog.
// The watchdog counts cycles spent waiting on the activation unit
// (WAIT_ACK / WAIT_CPL). When it reaches TIMEOUT_CYCLES, the FSM parks in ERR
// with err raised, until the next job_start. Without the macro, err is tied 0.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   job_start             one-cycle job request, honoured only when idle
//   job_act_type[1:0]     activation select, sampled with job_start
//   job_busy              high whenever a job is in progress (or in ERR)
//   job_done              one-cycle pulse at job completion
//   vec_valid/vec_ready   wavefront handshake from the array drain
//   vec_data              one wavefront vector (NUM_VALUES x DATA_WIDTH)
//   act_start             one-cycle start pulse to the activation unit
//   act_input_done        one-cycle pulse alongside the last act_start
//   act_type[1:0]         latched activation type
//   act_in_value          registered wavefront presented to the unit
//   act_ready             activation unit idle
//   act_output_done       unit finished the current wavefront (pulse)
//   act_output_complete   unit has flattened the full matrix (level)
//   diag_cnt[7:0]         wavefronts completed in the current job
//   err                   watchdog error flag
// ---------------------------------------------------------------------------
module act_layer_sequencer #(
   parameter int DATA_WIDTH     = 32,
   parameter int MAT_ROWS       = 3,
   parameter int MAT_COLS       = 3,
   parameter int NUM_VALUES     = MAT_ROWS + MAT_COLS - 1,
   parameter int NUM_DIAGS      = (MAT_ROWS >= MAT_COLS) ? MAT_ROWS : MAT_COLS,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             job_start,
   input  logic [1:0]                       job_act_type,
   output logic                             job_busy,
   output logic                             job_done,
   input  logic                             vec_valid,
   input  logic [DATA_WIDTH*NUM_VALUES-1:0] vec_data,
   output logic                             vec_ready,
   output logic                             act_start,
   output logic                             act_input_done,
   output logic [1:0]                       act_type,
   output logic [DATA_WIDTH*NUM_VALUES-1:0] act_in_value,
   input  logic                             act_ready,
   input  logic                             act_output_done,
   input  logic                             act_output_complete,
   output logic [7:0]                       diag_cnt,
   output logic                             err
);

   localparam int         VEC_W    = DATA_WIDTH * NUM_VALUES;
   localparam logic [7:0] LAST_IDX = 8'(NUM_DIAGS - 1);

   // diag_cnt is 8 bits wide, and the watchdog counter is 16 bits wide.
   if (NUM_DIAGS < 1 || NUM_DIAGS > 255 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
      $error("act_layer_sequencer: NUM_DIAGS or TIMEOUT_CYCLES out of range");
   end

`ifdef ACT_SEQ_TIMEOUT_EN
   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_VEC, S_WAIT_ACK, S_WAIT_CPL, S_FINISH, S_ERR
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_VEC, S_WAIT_ACK, S_WAIT_CPL, S_FINISH
   } state_t;
`endif

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_vec_ready;
   logic               w_handshake;
   logic               w_diag_inc;
   logic               w_job_load;
   logic [1:0]         r_act_type;
   logic [7:0]         r_diag_cnt;
   logic               r_act_start;
   logic               r_input_done;
   logic [VEC_W-1:0]   r_act_in_value;

`ifdef ACT_SEQ_TIMEOUT_EN
   logic [15:0]        r_wd_cnt;
   logic               r_err;
   logic               w_wd_expired;
   logic               w_wd_active;

   // The counter starts at 0 on the first waiting cycle. Expiring at LIMIT-1
   // therefore leaves the state after exactly TIMEOUT_CYCLES cycles.
   assign w_wd_active  = (r_state == S_WAIT_ACK) || (r_state == S_WAIT_CPL);
   assign w_wd_expired = w_wd_active && (r_wd_cnt == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wd_cnt <= '0;
         r_err    <= 1'b0;
      end else begin
         if (!w_wd_active || (w_state_nxt != r_state))
            r_wd_cnt <= '0;
         else
            r_wd_cnt <= r_wd_cnt + 16'd1;

         if (w_job_load)
            r_err <= 1'b0;
         else if ((w_state_nxt == S_ERR) && (r_state != S_ERR))
            r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   // Next-state / control decode
   always_comb begin
      w_state_nxt = r_state;
      w_vec_ready = 1'b0;
      w_handshake = 1'b0;
      w_diag_inc  = 1'b0;
      w_job_load  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (job_start) begin
               w_job_load  = 1'b1;
               w_state_nxt = S_WAIT_VEC;
            end
         end
         S_WAIT_VEC: begin
            // Accept only when the activation unit can take the wavefront.
            w_vec_ready = act_ready;
            if (vec_valid && act_ready) begin
               w_handshake = 1'b1;
               w_state_nxt = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (act_output_done) begin
               w_diag_inc  = 1'b1;
               // The old count being the last index means the new count is NUM_DIAGS.
               w_state_nxt = (r_diag_cnt == LAST_IDX) ? S_WAIT_CPL : S_WAIT_VEC;
            end
`ifdef ACT_SEQ_TIMEOUT_EN
            else if (w_wd_expired) begin
               w_state_nxt = S_ERR;
            end
`endif
         end
         S_WAIT_CPL: begin
            if (act_output_complete)
               w_state_nxt = S_FINISH;
`ifdef ACT_SEQ_TIMEOUT_EN
            else if (w_wd_expired)
               w_state_nxt = S_ERR;
`endif
         end
         S_FINISH: begin
            w_state_nxt = S_IDLE;
         end
`ifdef ACT_SEQ_TIMEOUT_EN
         S_ERR: begin
            if (job_start) begin
               w_job_load  = 1'b1;
               w_state_nxt = S_WAIT_VEC;
            end
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Job and wavefront registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_act_type     <= 2'b00;
         r_diag_cnt     <= 8'd0;
         r_act_start    <= 1'b0;
         r_input_done   <= 1'b0;
         r_act_in_value <= '0;
      end else begin
         r_act_start  <= w_handshake;
         r_input_done <= w_handshake && (r_diag_cnt == LAST_IDX);
         if (w_job_load) begin
            r_act_type <= job_act_type;
            r_diag_cnt <= 8'd0;
         end else if (w_diag_inc) begin
            r_diag_cnt <= r_diag_cnt + 8'd1;
         end
         if (w_handshake)
            r_act_in_value <= vec_data;
      end
   end

   assign job_busy       = (r_state != S_IDLE);
   assign job_done       = (r_state == S_FINISH);
   assign vec_ready      = w_vec_ready;
   assign act_start      = r_act_start;
   assign act_input_done = r_input_done;
   assign act_type       = r_act_type;
   assign act_in_value   = r_act_in_value;
   assign diag_cnt       = r_diag_cnt;

endmodule
